// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and helpers for the next-PC generator and its BTB.
//   CTR_*      : 2-bit saturating direction counter encodings
//   ctr_next() : saturating counter step toward the resolved direction
//   idx_w()    : BTB index width for a given entry count
//   tag_w()    : BTB tag width for a given PC width and entry count
package npc_pkg;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end else begin
         res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
      end
      return res;
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // The two low PC bits are always zero and are excluded from index and tag.
   function automatic int unsigned tag_w(input int unsigned pc_w, input int unsigned depth);
      return pc_w - idx_w(depth) - 2;
   endfunction

endpackage

// File: rtl/btb_bank.sv
// btb_bank: direct-mapped branch target buffer with 2-bit direction counters.
//   clk, reset          : clock, asynchronous active-high reset
//   lk_pc_i             : lookup address (combinational read, old contents on collision)
//   lk_taken_o          : entry hits and its counter predicts taken
//   lk_target_o         : stored target of the indexed entry (low bits zero)
//   upd_valid_i/pc/taken/target : training port for resolved branches and j/jal
module btb_bank
   import npc_pkg::*;
#(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] lk_pc_i,
   output logic            lk_taken_o,
   output logic [PC_W-1:0] lk_target_o,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i
);

   localparam int unsigned IDX_W = idx_w(DEPTH);
   localparam int unsigned TAG_W = tag_w(PC_W, DEPTH);

   // Targets are kept as word addresses; the zero byte offset is reattached on read.
   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [PC_W-3:0]  target_q [DEPTH];
   logic [1:0]       ctr_q    [DEPTH];

   logic             valid_d  [DEPTH];
   logic [TAG_W-1:0] tag_d    [DEPTH];
   logic [PC_W-3:0]  target_d [DEPTH];
   logic [1:0]       ctr_d    [DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             unused_lsbs;

   assign lk_idx  = lk_pc_i[IDX_W+1:2];
   assign lk_tag  = lk_pc_i[PC_W-1:IDX_W+2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i[PC_W-1:IDX_W+2];

   assign unused_lsbs = ^{lk_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

   // Lookup reads only the registered arrays, so a same-cycle update is not bypassed.
   assign lk_taken_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
   assign lk_target_o = {target_q[lk_idx], 2'b00};

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_valid_i) begin
         if (upd_hit) begin
            ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken_i);
            if (upd_taken_i) begin
               target_d[upd_idx] = upd_target_i[PC_W-1:2];
            end
         end else if (upd_taken_i) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target_i[PC_W-1:2];
            ctr_d[upd_idx]    = CTR_WT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

endmodule

// File: rtl/npc_bpred.sv
// npc_bpred: registered fetch PC with BTB-based next-PC prediction.
//   clk, reset                 : clock, asynchronous active-high reset
//   stall_i                    : hold the fetch PC
//   redirect_i, redirect_pc_i  : EX correction; wins over stall
//   upd_*                      : BTB training from resolved branches and j/jal
//   pc_o, pc_plus4_o           : current fetch PC and its sequential successor
//   pred_taken_o, pred_target_o: prediction for pc_o and the predicted next PC
module npc_bpred
   import npc_pkg::*;
#(
   parameter int unsigned     PC_W      = 32,
   parameter int unsigned     BTB_DEPTH = 16,
   parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_3000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_plus4_o,
   output logic            pred_taken_o,
   output logic [PC_W-1:0] pred_target_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] btb_target;
   logic            btb_taken;
   logic            unused_redir_lsbs;

   btb_bank #(
      .PC_W  (PC_W),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk          (clk),
      .reset        (reset),
      .lk_pc_i      (pc_q),
      .lk_taken_o   (btb_taken),
      .lk_target_o  (btb_target),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_taken_i  (upd_taken_i),
      .upd_target_i (upd_target_i)
   );

   assign unused_redir_lsbs = ^redirect_pc_i[1:0];

   // Natural-width add wraps modulo 2^PC_W.
   assign pc_plus4_o    = pc_q + PC_W'(4);
   assign pc_o          = pc_q;
   assign pred_taken_o  = btb_taken;
   assign pred_target_o = btb_taken ? btb_target : pc_plus4_o;

   always_comb begin
      pc_d = pred_target_o;
      if (redirect_i) begin
         pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
      end else if (stall_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_npc_bpred.sv
// Testbench for npc_bpred: directed stimulus, a word-address keyed model of the
// BTB and fetch PC checked every cycle, plus hand-computed literal expectations.
module tb_npc_bpred;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;

   logic        rst2;
   logic        z_bit;
   logic [31:0] z_word;
   logic [31:0] pc2;
   logic [31:0] pc2_plus4;
   logic        pred2;
   logic [31:0] pred2_target;

   int total = 0;
   int bad   = 0;

   npc_bpred dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o)
   );

   npc_bpred #(
      .RESET_PC (32'hFFFF_FFF8)
   ) dut_wrap (
      .clk           (clk),
      .reset         (rst2),
      .stall_i       (z_bit),
      .redirect_i    (z_bit),
      .redirect_pc_i (z_word),
      .upd_valid_i   (z_bit),
      .upd_pc_i      (z_word),
      .upd_taken_i   (z_bit),
      .upd_target_i  (z_word),
      .pc_o          (pc2),
      .pc_plus4_o    (pc2_plus4),
      .pred_taken_o  (pred2),
      .pred_target_o (pred2_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each slot remembers which instruction word owns it.
   localparam int N = 16;
   logic        m_valid [N];
   logic [31:0] m_word  [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   logic [31:0] m_pc;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic m_pred(input logic [31:0] pc);
      int s = slot(pc);
      return m_valid[s] && (m_word[s] == (pc >> 2)) && (m_ctr[s] >= 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 32'h3000;
         for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
         end
      end else begin
         logic [31:0] nxt;
         int s;
         if (redirect_i)   nxt = redirect_pc_i & ~32'd3;
         else if (stall_i) nxt = m_pc;
         else              nxt = m_next(m_pc);
         if (upd_valid_i) begin
            s = slot(upd_pc_i);
            if (m_valid[s] && m_word[s] == (upd_pc_i >> 2)) begin
               if (upd_taken_i) begin
                  m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                  m_tgt[s] = upd_target_i & ~32'd3;
               end else begin
                  m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
               end
            end else if (upd_taken_i) begin
               m_valid[s] = 1'b1;
               m_word[s]  = upd_pc_i >> 2;
               m_tgt[s]   = upd_target_i & ~32'd3;
               m_ctr[s]   = 2;
            end
         end
         m_pc = nxt;
      end
   end

   always @(negedge clk) begin
      chk("model_pc", pc_o, m_pc);
      chk("model_pc_plus4", pc_plus4_o, m_pc + 32'd4);
      chk("model_pred_taken", {31'd0, pred_taken_o}, {31'd0, m_pred(m_pc)});
      chk("model_pred_target", pred_target_o, m_next(m_pc));
   end

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      upd_valid_i  = 1'b1;
      upd_pc_i     = pc;
      upd_taken_i  = taken;
      upd_target_i = tgt;
   endtask

   task automatic redir(input logic [31:0] pc);
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
   endtask

   task automatic idle();
      upd_valid_i = 1'b0;
      redirect_i  = 1'b0;
   endtask

   initial begin
      stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
      upd_valid_i = 0; upd_pc_i = '0; upd_taken_i = 0; upd_target_i = '0;
      z_bit = 0; z_word = '0; rst2 = 1'b1;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // sequential fetch after reset
      #1 chk("rst_pc", pc_o, 32'h3000);
      chk("rst_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("rst_tgt", pred_target_o, 32'h3004);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk); #1;
         chk("seq_pc", pc_o, 32'h3000 + 32'(4 * k));
         chk("seq_pred", {31'd0, pred_taken_o}, 32'd0);
      end
      // asynchronous reset between edges
      #2 reset = 1'b1;
      #1 chk("async_rst_pc", pc_o, 32'h3000);
      chk("async_rst_p4", pc_plus4_o, 32'h3004);
      @(negedge clk);
      reset = 1'b0;

      // allocate and predict
      upd(32'h3010, 1'b1, 32'h3040);
      @(negedge clk); idle(); redir(32'h300C);
      @(negedge clk); idle();
      #1 chk("alloc_pc0", pc_o, 32'h300C);
      @(negedge clk); #1;
      chk("alloc_pc", pc_o, 32'h3010);
      chk("alloc_pred", {31'd0, pred_taken_o}, 32'd1);
      chk("alloc_tgt", pred_target_o, 32'h3040);
      @(negedge clk); #1 chk("alloc_next", pc_o, 32'h3040);

      // hysteresis: 10 -> 01 predicts not taken
      upd(32'h3010, 1'b0, 32'h0); redir(32'h3010);
      @(negedge clk); idle();
      #1 chk("hyst_nt_pred", {31'd0, pred_taken_o}, 32'd0);
      @(negedge clk); #1 chk("hyst_nt_next", pc_o, 32'h3014);
      // 01 -> 10 -> 11 -> 11, then 11 -> 10 still taken
      for (int k = 0; k < 3; k++) begin
         upd(32'h3010, 1'b1, 32'h3040);
         @(negedge clk);
      end
      upd(32'h3010, 1'b0, 32'h0);
      @(negedge clk); idle(); redir(32'h3010);
      @(negedge clk); idle();
      #1 chk("hyst_sat_pred", {31'd0, pred_taken_o}, 32'd1);
      @(negedge clk); #1 chk("hyst_sat_next", pc_o, 32'h3040);
      // second not-taken shows the counter saturated: 10 -> 01
      upd(32'h3010, 1'b0, 32'h0); redir(32'h3010);
      @(negedge clk); idle();
      #1 chk("hyst_sat2_pred", {31'd0, pred_taken_o}, 32'd0);

      // redirect beats stall, stall holds
      redir(32'h3103); stall_i = 1'b1;
      @(negedge clk); idle();
      #1 chk("redir_pc", pc_o, 32'h3100);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1 chk("stall_pc", pc_o, 32'h3100);
      end
      stall_i = 1'b0;

      // aliasing: 0x3050 evicts 0x3010
      upd(32'h3050, 1'b1, 32'h3080); redir(32'h3010);
      @(negedge clk); idle();
      #1 chk("alias_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("alias_tgt", pred_target_o, 32'h3014);
      @(negedge clk); #1 chk("alias_next", pc_o, 32'h3014);
      // collision: lookup sees old entry while it is being replaced
      redir(32'h3050);
      @(negedge clk); idle(); stall_i = 1'b1;
      upd(32'h3010, 1'b1, 32'h3022);
      #1 chk("coll_old_pred", {31'd0, pred_taken_o}, 32'd1);
      chk("coll_old_tgt", pred_target_o, 32'h3080);
      @(negedge clk); idle();
      #1 chk("coll_new_pred", {31'd0, pred_taken_o}, 32'd0);
      chk("coll_new_tgt", pred_target_o, 32'h3054);
      stall_i = 1'b0;

      // miss, not taken: nothing allocates
      #2 reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         upd(32'h3000 + 32'(4 * k), 1'b0, 32'h3200);
         @(negedge clk);
      end
      idle(); redir(32'h3000);
      @(negedge clk); idle();
      for (int k = 0; k < N; k++) begin
         #1 chk("mnt_pred", {31'd0, pred_taken_o}, 32'd0);
         @(negedge clk);
      end

      // wrap of the PC adder
      rst2 = 1'b0;
      #1 chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
      @(negedge clk); #1 chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
      chk("wrap_p4", pc2_plus4, 32'h0000_0000);
      @(negedge clk); #1 chk("wrap_pc2", pc2, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
